// File: rtl/smart_irrigation_ctrl.sv
// Multi-zone irrigation controller: auto zone sequencer, rain/moisture/quota gating,
// debounced flow-meter usage accounting with peak-sunlight double-rate counting.
module smart_irrigation_ctrl #(
  parameter int NUM_USERS      = 4,
  parameter int WIDTH          = 6,
  parameter int DEBOUNCE_WIDTH = 8,
  parameter int DEBOUNCE_LOCK  = 3,
  parameter int ZONE_TICKS     = 4,
  parameter int DAY_TICKS      = 64,
  parameter int PEAK_START     = 0,
  parameter int PEAK_END       = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_1hz,
  input  logic                         flow_pulse_raw,
  input  logic                         moisture_dry,
  input  logic                         rain,
  input  logic                         auto_cycle_start,
  input  logic [$clog2(NUM_USERS)-1:0] user_select_manual,
  input  logic                         reset_user,
  input  logic                         quota_wr,
  input  logic [WIDTH-1:0]             quota_set,
  input  logic                         manual_override,
  output logic                         valve_on,
  output logic [NUM_USERS-1:0]         quota_exceeded,
  output logic [WIDTH-1:0]             usage_out,
  output logic [WIDTH-1:0]             quota_out,
  output logic                         flow_boost_on,
  output logic                         sequencer_active,
  output logic [$clog2(NUM_USERS)-1:0] current_zone
);

  localparam int ZW   = $clog2(NUM_USERS);
  localparam int TW   = $clog2(ZONE_TICKS + 1);
  localparam int TODW = $clog2(DAY_TICKS);

  typedef enum logic {IDLE, WATER} state_t;

  state_t                    state_q, state_d;
  logic [ZW-1:0]             zone_q, zone_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [TODW-1:0]           tod_q, tod_d;
  logic [1:0]                hz_sync_q;
  logic                      hz_prev_q;
  logic [1:0]                flow_sync_q;
  logic                      flow_prev_q;
  logic [DEBOUNCE_WIDTH-1:0] lock_q, lock_d;
  logic                      valve_q, valve_d;
  logic [WIDTH-1:0]          usage_q [NUM_USERS];
  logic [WIDTH-1:0]          usage_d [NUM_USERS];
  logic [WIDTH-1:0]          quota_q [NUM_USERS];
  logic [WIDTH-1:0]          quota_d [NUM_USERS];

  logic             tick;
  logic             flow_edge;
  logic             accept;
  logic             peak;
  logic             paused;
  logic             advance;
  logic [WIDTH-1:0] step_amt;
  logic [WIDTH:0]   sum;

  assign tick      = hz_sync_q[1] & ~hz_prev_q;
  assign flow_edge = flow_sync_q[1] & ~flow_prev_q;
  assign accept    = flow_edge && (lock_q == '0);
  // Signed compare keeps a PEAK_START of 0 meaningful without an always-true unsigned test.
  assign peak      = (int'(tod_q) >= PEAK_START) && (int'(tod_q) < PEAK_END);

  assign sequencer_active = (state_q == WATER);
  assign current_zone     = sequencer_active ? zone_q : user_select_manual;
  assign valve_on         = valve_q;
  assign flow_boost_on    = valve_q && peak;
  assign usage_out        = usage_q[current_zone];
  assign quota_out        = quota_q[current_zone];
  assign step_amt         = flow_boost_on ? WIDTH'(2) : WIDTH'(1);
  assign sum              = {1'b0, usage_q[current_zone]} + {1'b0, step_amt};

  always_comb begin
    for (int unsigned i = 0; i < NUM_USERS; i++) begin
      quota_exceeded[i] = (usage_q[i] >= quota_q[i]);
    end
  end

  always_comb begin
    tod_d = tod_q;
    if (tick) begin
      tod_d = (tod_q == TODW'(DAY_TICKS - 1)) ? '0 : tod_q + 1'b1;
    end
    if (accept) begin
      lock_d = DEBOUNCE_WIDTH'(DEBOUNCE_LOCK);
    end else if (lock_q != '0) begin
      lock_d = lock_q - 1'b1;
    end else begin
      lock_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    zone_d  = zone_q;
    timer_d = timer_q;
    paused  = rain && !manual_override;
    advance = (timer_q == TW'(ZONE_TICKS)) || (!moisture_dry && !manual_override) ||
              quota_exceeded[zone_q];
    case (state_q)
      IDLE: begin
        if (auto_cycle_start) begin
          state_d = WATER;
          zone_d  = '0;
          timer_d = '0;
        end
      end
      WATER: begin
        if (advance) begin
          timer_d = '0;
          if (zone_q == ZW'(NUM_USERS - 1)) begin
            state_d = IDLE;
          end else begin
            zone_d = zone_q + 1'b1;
          end
        end else if (tick && !paused) begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valve_d = !quota_exceeded[current_zone] &&
              (manual_override || (sequencer_active && moisture_dry && !rain));
  end

  // A reset_user clear is applied after the increment so it wins on the same zone.
  always_comb begin
    for (int unsigned i = 0; i < NUM_USERS; i++) begin
      usage_d[i] = usage_q[i];
      quota_d[i] = quota_q[i];
    end
    if (accept && valve_q) begin
      usage_d[current_zone] = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    end
    if (reset_user) begin
      usage_d[user_select_manual] = '0;
    end
    if (quota_wr) begin
      quota_d[user_select_manual] = quota_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      zone_q      <= '0;
      timer_q     <= '0;
      tod_q       <= '0;
      hz_sync_q   <= '0;
      hz_prev_q   <= 1'b0;
      flow_sync_q <= '0;
      flow_prev_q <= 1'b0;
      lock_q      <= '0;
      valve_q     <= 1'b0;
      for (int unsigned i = 0; i < NUM_USERS; i++) begin
        usage_q[i] <= '0;
        quota_q[i] <= '1;
      end
    end else begin
      state_q     <= state_d;
      zone_q      <= zone_d;
      timer_q     <= timer_d;
      tod_q       <= tod_d;
      hz_sync_q   <= {hz_sync_q[0], clk_1hz};
      hz_prev_q   <= hz_sync_q[1];
      flow_sync_q <= {flow_sync_q[0], flow_pulse_raw};
      flow_prev_q <= flow_sync_q[1];
      lock_q      <= lock_d;
      valve_q     <= valve_d;
      for (int unsigned i = 0; i < NUM_USERS; i++) begin
        usage_q[i] <= usage_d[i];
        quota_q[i] <= quota_d[i];
      end
    end
  end

endmodule

// File: tb/tb_smart_irrigation_ctrl.sv
// Directed bench for smart_irrigation_ctrl: quota setup, auto cycle, quota hit,
// rain pause, zone timeout, manual override, usage clear, debounce, peak window, async reset.
module tb_smart_irrigation_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz = 1'b0;
  logic       flow_pulse_raw = 1'b0;
  logic       moisture_dry = 1'b0;
  logic       rain = 1'b0;
  logic       auto_cycle_start = 1'b0;
  logic [1:0] user_select_manual = 2'd0;
  logic       reset_user = 1'b0;
  logic       quota_wr = 1'b0;
  logic [5:0] quota_set = 6'd0;
  logic       manual_override = 1'b0;
  logic       valve_on;
  logic [3:0] quota_exceeded;
  logic [5:0] usage_out;
  logic [5:0] quota_out;
  logic       flow_boost_on;
  logic       sequencer_active;
  logic [1:0] current_zone;

  int n_assert = 0;
  int n_fail   = 0;

  smart_irrigation_ctrl #(
    .NUM_USERS(4), .WIDTH(6), .DEBOUNCE_WIDTH(8), .DEBOUNCE_LOCK(3),
    .ZONE_TICKS(4), .DAY_TICKS(64), .PEAK_START(0), .PEAK_END(32)
  ) dut (
    .clk(clk), .rst(rst), .clk_1hz(clk_1hz), .flow_pulse_raw(flow_pulse_raw),
    .moisture_dry(moisture_dry), .rain(rain), .auto_cycle_start(auto_cycle_start),
    .user_select_manual(user_select_manual), .reset_user(reset_user),
    .quota_wr(quota_wr), .quota_set(quota_set), .manual_override(manual_override),
    .valve_on(valve_on), .quota_exceeded(quota_exceeded), .usage_out(usage_out),
    .quota_out(quota_out), .flow_boost_on(flow_boost_on),
    .sequencer_active(sequencer_active), .current_zone(current_zone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One-clk raw pulse; returns 5 clks later, after the accepted edge has been counted.
  task automatic pulse();
    flow_pulse_raw = 1'b1;
    step(1);
    flow_pulse_raw = 1'b0;
    step(4);
  endtask

  task automatic tick();
    clk_1hz = 1'b1;
    step(3);
    clk_1hz = 1'b0;
    step(3);
  endtask

  initial begin
    step(3);
    rst = 1'b0;
    step(1);
    chk("rst_valve", valve_on, 0);
    chk("rst_seq", sequencer_active, 0);
    chk("rst_zone", current_zone, 0);
    chk("rst_usage", usage_out, 0);
    chk("rst_quota", quota_out, 63);
    chk("rst_qx", quota_exceeded, 0);
    chk("rst_boost", flow_boost_on, 0);

    for (int k = 0; k < 4; k++) begin
      user_select_manual = 2'(k);
      quota_set = 6'(20 + 5 * k);
      quota_wr = 1'b1;
      step(1);
    end
    quota_wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      user_select_manual = 2'(k);
      #1;
      chk("quota_rd", quota_out, 20 + 5 * k);
    end
    chk("qx_after_wr", quota_exceeded, 0);

    // Automatic cycle, zone 0, peak window (tod = 0)
    user_select_manual = 2'd3;
    moisture_dry = 1'b1;
    auto_cycle_start = 1'b1;
    step(1);
    auto_cycle_start = 1'b0;
    chk("start_seq", sequencer_active, 1);
    chk("start_zone", current_zone, 0);
    chk("start_valve_lag", valve_on, 0);
    step(1);
    chk("start_valve", valve_on, 1);
    chk("start_boost", flow_boost_on, 1);
    for (int p = 1; p <= 9; p++) begin
      pulse();
      chk("usage_z0", usage_out, 2 * p);
    end
    flow_pulse_raw = 1'b1;
    step(1);
    flow_pulse_raw = 1'b0;
    step(2);
    chk("hit_usage", usage_out, 20);
    chk("hit_qx", quota_exceeded, 4'b0001);
    chk("hit_valve_still", valve_on, 1);
    chk("hit_zone_still", current_zone, 0);
    step(1);
    chk("hit_valve_drop", valve_on, 0);
    chk("hit_advance", current_zone, 1);
    step(1);
    chk("z1_valve", valve_on, 1);
    pulse();
    chk("z1_usage", usage_out, 2);

    // Restart ignored while watering; rain pauses zone 1
    auto_cycle_start = 1'b1;
    step(1);
    auto_cycle_start = 1'b0;
    chk("restart_ignored", current_zone, 1);
    rain = 1'b1;
    step(1);
    chk("rain_valve", valve_on, 0);
    pulse();
    chk("rain_no_count", usage_out, 2);
    for (int t = 0; t < 4; t++) tick();
    chk("rain_hold_zone", current_zone, 1);
    chk("rain_hold_seq", sequencer_active, 1);
    rain = 1'b0;
    step(1);
    chk("rain_resume_valve", valve_on, 1);
    chk("rain_resume_zone", current_zone, 1);

    // Zone timeout after ZONE_TICKS ticks
    for (int t = 0; t < 3; t++) tick();
    chk("timer_3", current_zone, 1);
    tick();
    chk("timer_4_adv", current_zone, 2);
    chk("timer_4_valve", valve_on, 1);

    // Wet soil skips remaining zones to IDLE
    moisture_dry = 1'b0;
    user_select_manual = 2'd1;
    step(1);
    chk("wet_zone3", current_zone, 3);
    chk("wet_valve", valve_on, 0);
    step(1);
    chk("wet_idle", sequencer_active, 0);
    chk("idle_zone_sel", current_zone, 1);
    chk("idle_usage1", usage_out, 2);
    chk("idle_quota1", quota_out, 25);
    user_select_manual = 2'd0;
    #1;
    chk("usage0_frozen", usage_out, 20);
    chk("qx_z0", quota_exceeded, 4'b0001);

    // Manual override in IDLE beats rain and dry soil, not quota (tod = 8)
    rain = 1'b1;
    manual_override = 1'b1;
    user_select_manual = 2'd2;
    step(1);
    chk("ovr_valve", valve_on, 1);
    chk("ovr_boost", flow_boost_on, 1);
    pulse();
    chk("ovr_usage2", usage_out, 2);
    user_select_manual = 2'd0;
    step(1);
    chk("ovr_quota_block", valve_on, 0);

    // Quota write / usage clear
    manual_override = 1'b0;
    user_select_manual = 2'd1;
    quota_set = 6'd2;
    quota_wr = 1'b1;
    step(1);
    quota_wr = 1'b0;
    chk("qx_z1_set", quota_exceeded, 4'b0011);
    reset_user = 1'b1;
    step(1);
    chk("clr_usage1", usage_out, 0);
    chk("clr_qx", quota_exceeded, 4'b0001);
    step(1);
    reset_user = 1'b0;
    user_select_manual = 2'd2;
    reset_user = 1'b1;
    quota_wr = 1'b1;
    quota_set = 6'd0;
    step(1);
    reset_user = 1'b0;
    quota_wr = 1'b0;
    chk("both_usage2", usage_out, 0);
    chk("both_quota2", quota_out, 0);
    chk("both_qx", quota_exceeded, 4'b0101);

    // Clear wins over a simultaneous increment, then debounce lockout
    user_select_manual = 2'd3;
    manual_override = 1'b1;
    step(1);
    chk("z3_valve", valve_on, 1);
    flow_pulse_raw = 1'b1;
    step(1);
    flow_pulse_raw = 1'b0;
    step(1);
    reset_user = 1'b1;
    step(1);
    reset_user = 1'b0;
    chk("clr_wins", usage_out, 0);
    pulse();
    chk("lockout_reject", usage_out, 0);
    pulse();
    chk("after_lockout", usage_out, 2);

    // Peak window boundary: tod 31 boosted, tod 32 not
    for (int t = 0; t < 23; t++) tick();
    chk("tod31_boost", flow_boost_on, 1);
    tick();
    chk("tod32_boost", flow_boost_on, 0);
    pulse();
    chk("offpeak_inc", usage_out, 3);

    // Asynchronous reset mid-cycle
    manual_override = 1'b0;
    rain = 1'b0;
    moisture_dry = 1'b1;
    user_select_manual = 2'd0;
    auto_cycle_start = 1'b1;
    step(1);
    auto_cycle_start = 1'b0;
    step(2);
    chk("pre_rst_seq", sequencer_active, 1);
    chk("pre_rst_valve", valve_on, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valve", valve_on, 0);
    chk("arst_seq", sequencer_active, 0);
    chk("arst_zone", current_zone, 0);
    chk("arst_usage", usage_out, 0);
    chk("arst_quota", quota_out, 63);
    chk("arst_qx", quota_exceeded, 0);
    chk("arst_boost", flow_boost_on, 0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
